// File: rtl/front_lookup_pipe_pkg.sv
// rtl/front_lookup_pipe_pkg.sv - default constants and typedefs for the front lookup pipe
package front_pkg;

    localparam int HW         = 5;
    localparam int WW         = 5;
    localparam int ID_W       = 4;
    localparam int OCC_W      = 8;
    localparam int STRIP_CAP  = 128;
    localparam int NUM_STRIPS = 14;
    localparam int NUM_CAND   = 3;
    localparam int HSHIFT     = 2;

    typedef logic [ID_W-1:0]  strip_id_t;
    typedef logic [OCC_W-1:0] occ_t;

endpackage

// File: rtl/front_lookup_pipe_if.sv
// rtl/front_lookup_pipe_if.sv - request, occupancy-update and result signals of the lookup pipe
interface front_lookup_pipe_if #(
    parameter int HW       = front_pkg::HW,
    parameter int WW       = front_pkg::WW,
    parameter int NUM_CAND = front_pkg::NUM_CAND,
    parameter int ID_W     = front_pkg::ID_W,
    parameter int OCC_W    = front_pkg::OCC_W
);

    logic                      in_valid;
    logic                      in_ready;
    logic [HW-1:0]             height_in;
    logic [WW-1:0]             width_in;

    logic                      upd_valid;
    logic [ID_W-1:0]           upd_id;
    logic [OCC_W-1:0]          upd_width;

    logic                      out_valid;
    logic                      out_ready;
    logic [HW-1:0]             out_height;
    logic [WW-1:0]             out_width;
    logic [NUM_CAND*ID_W-1:0]  out_str_id;
    logic [NUM_CAND*OCC_W-1:0] out_occ;
    logic [NUM_CAND-1:0]       out_fit;

    modport master (
        output in_valid, height_in, width_in,
        output upd_valid, upd_id, upd_width,
        output out_ready,
        input  in_ready,
        input  out_valid, out_height, out_width, out_str_id, out_occ, out_fit
    );

    modport slave (
        input  in_valid, height_in, width_in,
        input  upd_valid, upd_id, upd_width,
        input  out_ready,
        output in_ready,
        output out_valid, out_height, out_width, out_str_id, out_occ, out_fit
    );

endinterface

// File: rtl/front_lookup_pipe_strip_finder.sv
// rtl/front_lookup_pipe_strip_finder.sv - maps a request height to its candidate strip ids
module strip_finder #(
    parameter int HW         = front_pkg::HW,
    parameter int ID_W       = front_pkg::ID_W,
    parameter int NUM_STRIPS = front_pkg::NUM_STRIPS,
    parameter int NUM_CAND   = front_pkg::NUM_CAND,
    parameter int HSHIFT     = front_pkg::HSHIFT
) (
    input  logic [HW-1:0]            height,
    output logic [NUM_CAND*ID_W-1:0] str_id
);

    // Each height class owns NUM_CAND consecutive strips; classes past the table map to none.
    function automatic logic [ID_W-1:0] cand_id(input logic [HW-1:0] h, input int slot);
        int v;
        v = (int'(h) >> HSHIFT) * NUM_CAND + slot + 1;
        if (h != '0 && v <= NUM_STRIPS)
            return ID_W'(v);
        return '0;
    endfunction

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_cand
        assign str_id[g*ID_W +: ID_W] = cand_id(height, g);
    end

endmodule

// File: rtl/front_lookup_pipe.sv
// rtl/front_lookup_pipe.sv - three-stage strip lookup: sample, candidate find, occupancy read and fit
module front_lookup_pipe #(
    parameter int HW         = front_pkg::HW,
    parameter int WW         = front_pkg::WW,
    parameter int NUM_STRIPS = front_pkg::NUM_STRIPS,
    parameter int NUM_CAND   = front_pkg::NUM_CAND,
    parameter int ID_W       = front_pkg::ID_W,
    parameter int OCC_W      = front_pkg::OCC_W,
    parameter int STRIP_CAP  = front_pkg::STRIP_CAP,
    parameter int HSHIFT     = front_pkg::HSHIFT
) (
    input logic                clk,
    input logic                rst,
    front_lookup_pipe_if.slave bus
);

    logic                     adv;
    logic                     upd_ok;

    logic                     s1_valid;
    logic [HW-1:0]            s1_height;
    logic [WW-1:0]            s1_width;

    logic                     s2_valid;
    logic [HW-1:0]            s2_height;
    logic [WW-1:0]            s2_width;
    logic [ID_W-1:0]          s2_id [NUM_CAND];

    logic                     s3_valid;
    logic [HW-1:0]            s3_height;
    logic [WW-1:0]            s3_width;
    logic [ID_W-1:0]          s3_id  [NUM_CAND];
    logic [OCC_W-1:0]         s3_occ [NUM_CAND];
    logic [NUM_CAND-1:0]      s3_fit;

    logic [OCC_W-1:0]         occ_table [0:NUM_STRIPS];
    logic [NUM_CAND*ID_W-1:0] find_id;
    logic [OCC_W-1:0]         rd_occ [NUM_CAND];
    logic [NUM_CAND-1:0]      rd_fit;

    // Sum is one bit wider than the occupancy so a full strip plus width cannot wrap.
    function automatic logic fits(input logic [ID_W-1:0] id, input logic [OCC_W-1:0] occ,
                                  input logic [WW-1:0] width);
        logic [OCC_W:0] sum;
        sum = {1'b0, occ} + (OCC_W+1)'(width);
        return (id != '0) && (sum <= (OCC_W+1)'(STRIP_CAP));
    endfunction

    assign adv          = !s3_valid || bus.out_ready;
    assign bus.in_ready = adv;
    assign upd_ok       = bus.upd_valid && (bus.upd_id != '0) && (bus.upd_id <= ID_W'(NUM_STRIPS));

    strip_finder #(
        .HW         (HW),
        .ID_W       (ID_W),
        .NUM_STRIPS (NUM_STRIPS),
        .NUM_CAND   (NUM_CAND),
        .HSHIFT     (HSHIFT)
    ) u_strip_finder (
        .height (s1_height),
        .str_id (find_id)
    );

    // A same-cycle update to a strip being read wins over the stored value.
    always_comb begin
        rd_fit = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            rd_occ[i] = '0;
            if (s2_id[i] != '0)
                rd_occ[i] = (upd_ok && bus.upd_id == s2_id[i]) ? bus.upd_width : occ_table[s2_id[i]];
            rd_fit[i] = fits(s2_id[i], rd_occ[i], s2_width);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= NUM_STRIPS; k++)
                occ_table[k] <= OCC_W'(STRIP_CAP);
        end else if (upd_ok) begin
            occ_table[bus.upd_id] <= bus.upd_width;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_height <= '0;
            s1_width  <= '0;
            s2_valid  <= 1'b0;
            s2_height <= '0;
            s2_width  <= '0;
            s3_valid  <= 1'b0;
            s3_height <= '0;
            s3_width  <= '0;
            s3_fit    <= '0;
            for (int i = 0; i < NUM_CAND; i++) begin
                s2_id[i]  <= '0;
                s3_id[i]  <= '0;
                s3_occ[i] <= '0;
            end
        end else if (adv) begin
            s1_valid  <= bus.in_valid;
            s1_height <= bus.height_in;
            s1_width  <= bus.width_in;
            s2_valid  <= s1_valid;
            s2_height <= s1_height;
            s2_width  <= s1_width;
            s3_valid  <= s2_valid;
            s3_height <= s2_height;
            s3_width  <= s2_width;
            s3_fit    <= rd_fit;
            for (int i = 0; i < NUM_CAND; i++) begin
                s2_id[i]  <= find_id[i*ID_W +: ID_W];
                s3_id[i]  <= s2_id[i];
                s3_occ[i] <= rd_occ[i];
            end
        end else begin
            // A held result keeps tracking table writes to its own strips.
            for (int i = 0; i < NUM_CAND; i++) begin
                if (upd_ok && s3_id[i] != '0 && bus.upd_id == s3_id[i]) begin
                    s3_occ[i] <= bus.upd_width;
                    s3_fit[i] <= fits(s3_id[i], bus.upd_width, s3_width);
                end
            end
        end
    end

    assign bus.out_valid  = s3_valid;
    assign bus.out_height = s3_height;
    assign bus.out_width  = s3_width;
    assign bus.out_fit    = s3_fit;

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_out
        assign bus.out_str_id[g*ID_W +: ID_W] = s3_id[g];
        assign bus.out_occ[g*OCC_W +: OCC_W]  = s3_occ[g];
    end

endmodule

// File: tb/tb_front_lookup_pipe.sv
// tb/tb_front_lookup_pipe.sv - scoreboard bench for front_lookup_pipe with a table reference model
module tb_front_lookup_pipe;
    import front_pkg::*;

    typedef struct {
        int height;
        int width;
    } req_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    req_t sb [$];
    int   ref_tab [1:NUM_STRIPS];
    int   lat;

    always #5 clk = ~clk;

    front_lookup_pipe_if #(.HW(HW), .WW(WW), .NUM_CAND(NUM_CAND), .ID_W(ID_W), .OCC_W(OCC_W)) bus ();

    front_lookup_pipe #(
        .HW(HW), .WW(WW), .NUM_STRIPS(NUM_STRIPS), .NUM_CAND(NUM_CAND), .ID_W(ID_W),
        .OCC_W(OCC_W), .STRIP_CAP(STRIP_CAP), .HSHIFT(HSHIFT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_id(input int h, input int slot);
        int id;
        id = (h / (1 << HSHIFT)) * NUM_CAND + slot + 1;
        return (h != 0 && id <= NUM_STRIPS) ? id : 0;
    endfunction

    function automatic int exp_occ(input int id);
        return (id == 0) ? 0 : ref_tab[id];
    endfunction

    function automatic int exp_fit(input int id, input int w);
        return (id != 0 && exp_occ(id) + w <= STRIP_CAP) ? 1 : 0;
    endfunction

    // Reference occupancy table: reset fills to capacity, in-range writes land at the edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= NUM_STRIPS; k++)
                ref_tab[k] = STRIP_CAP;
        end else if (bus.upd_valid && bus.upd_id >= 1 && bus.upd_id <= NUM_STRIPS) begin
            ref_tab[int'(bus.upd_id)] = int'(bus.upd_width);
        end
    end

    // A presented result always reflects the current table contents for its strips.
    always @(negedge clk) begin
        req_t r;
        req_t n;
        int   id;
        if (rst) begin
            sb.delete();
        end else begin
            check("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", bus.out_valid, 1'b0);
                end else begin
                    r = sb[0];
                    check("out_height", bus.out_height, r.height);
                    check("out_width", bus.out_width, r.width);
                    for (int i = 0; i < NUM_CAND; i++) begin
                        id = exp_id(r.height, i);
                        check($sformatf("out_id%0d", i), bus.out_str_id[i*ID_W +: ID_W], id);
                        check($sformatf("out_occ%0d", i), bus.out_occ[i*OCC_W +: OCC_W], exp_occ(id));
                        check($sformatf("out_fit%0d", i), bus.out_fit[i], exp_fit(id, r.width));
                    end
                    if (bus.out_ready)
                        void'(sb.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                n.height = int'(bus.height_in);
                n.width  = int'(bus.width_in);
                sb.push_back(n);
            end
        end
    end

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.height_in = '0;
        bus.width_in  = '0;
        bus.upd_valid = 1'b0;
        bus.upd_id    = '0;
        bus.upd_width = '0;
    endtask

    task automatic send(input int h, input int w);
        int n;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b1;
        bus.height_in = HW'(h);
        bus.width_in  = WW'(w);
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 50) begin
                check("send_timeout", 1'b0, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic upd(input int id, input int w);
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b1;
        bus.upd_id    = ID_W'(id);
        bus.upd_width = OCC_W'(w);
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        if (!bus.out_valid)
            check("wait_out_timeout", bus.out_valid, 1'b1);
    endtask

    initial begin
        int bp_h [3];
        int got;
        int n;
        bp_h = '{1, 6, 9};

        // Reset with a same-cycle request and update that must both be dropped.
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.height_in = HW'(5);
        bus.width_in  = WW'(1);
        bus.upd_valid = 1'b1;
        bus.upd_id    = ID_W'(5);
        bus.upd_width = OCC_W'(7);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_str_id", bus.out_str_id, '0);
        check("rst_out_occ", bus.out_occ, '0);
        check("rst_out_fit", bus.out_fit, '0);
        check("rst_out_hw", {bus.out_height, bus.out_width}, '0);
        check("rst_in_ready", bus.in_ready, 1'b1);

        send(5, 10);
        wait_out(lat);
        check("latency", lat, 3);
        check("s1_ids", bus.out_str_id, 12'h654);
        check("s1_occ", bus.out_occ, 24'h808080);
        check("s1_fit", bus.out_fit, 3'b000);

        upd(5, 100);
        send(5, 20);
        wait_out(lat);
        check("s2_occ", bus.out_occ, 24'h806480);
        check("s2_fit", bus.out_fit, 3'b010);

        // Backpressure: three requests fill the pipe behind a stalled result.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid  = 1'b1;
            bus.height_in = HW'(bp_h[i]);
            bus.width_in  = WW'(i + 2);
            @(negedge clk);
            check("bp_accept", bus.in_ready, 1'b1);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("bp_in_ready", bus.in_ready, 1'b0);
            check("bp_hold_valid", bus.out_valid, 1'b1);
            check("bp_hold_height", bus.out_height, bp_h[0]);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                check("bp_order", bus.out_height, bp_h[got]);
                got++;
            end
        end
        check("bp_count", got, 3);
        repeat (3) begin
            @(negedge clk);
            check("bp_no_dup", bus.out_valid, 1'b0);
        end

        // Bypass: update lands on the same edge that loads S3.
        upd(5, 120);
        send(5, 20);
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b1;
        bus.upd_id    = ID_W'(5);
        bus.upd_width = OCC_W'(0);
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b0;
        @(negedge clk);
        check("byp_valid", bus.out_valid, 1'b1);
        check("byp_occ1", bus.out_occ[OCC_W +: OCC_W], 0);
        check("byp_fit1", bus.out_fit[1], 1'b1);

        // Refresh: update while the result is stalled at the output.
        upd(5, 120);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(5, 30);
        wait_out(lat);
        check("ref_pre_occ1", bus.out_occ[OCC_W +: OCC_W], 120);
        check("ref_pre_fit1", bus.out_fit[1], 1'b0);
        upd(5, 0);
        @(negedge clk);
        check("ref_occ1", bus.out_occ[OCC_W +: OCC_W], 0);
        check("ref_fit1", bus.out_fit[1], 1'b1);
        check("ref_ids", bus.out_str_id, 12'h654);
        check("ref_width", bus.out_width, 30);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Boundaries.
        send(20, 3);
        wait_out(lat);
        check("b_h20_ids", bus.out_str_id, '0);
        check("b_h20_occ", bus.out_occ, '0);
        check("b_h20_fit", bus.out_fit, '0);
        send(0, 3);
        wait_out(lat);
        check("b_h0_ids", bus.out_str_id, '0);
        upd(15, 9);
        upd(0, 9);
        send(16, 8);
        wait_out(lat);
        check("b_h16_ids", bus.out_str_id, 12'h0ed);
        check("b_h16_occ", bus.out_occ, 24'h008080);
        upd(13, 120);
        send(16, 8);
        wait_out(lat);
        check("b_fit_w8", bus.out_fit[0], 1'b1);
        send(16, 9);
        wait_out(lat);
        check("b_fit_w9", bus.out_fit[0], 1'b0);

        // Reset mid-flight discards requests and wins over an update.
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b1;
        bus.height_in = HW'(5);
        bus.width_in  = WW'(1);
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.upd_valid = 1'b1;
        bus.upd_id    = ID_W'(5);
        bus.upd_width = OCC_W'(55);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        repeat (4) begin
            @(negedge clk);
            check("rst_flush", bus.out_valid, 1'b0);
        end
        send(5, 0);
        wait_out(lat);
        check("rst_table", bus.out_occ, 24'h808080);

        // Random traffic against the scoreboard.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.height_in = HW'($urandom_range(0, 31));
            bus.width_in  = WW'($urandom_range(0, 31));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.upd_valid = ($urandom_range(0, 9) < 3);
            bus.upd_id    = ID_W'($urandom_range(0, 15));
            bus.upd_width = ($urandom_range(0, 1) == 1) ? OCC_W'($urandom_range(96, 140))
                                                        : OCC_W'($urandom_range(0, 255));
        end
        @(posedge clk);
        #1;
        idle();
        bus.out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", sb.size(), 0);
        repeat (2) @(negedge clk);
        check("drain_idle", bus.out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
